// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MEMWAIT} state_t;

    localparam logic [31:0] NOP_INSTR      = 32'h00000013;
    localparam int          DEF_REG_ADDR_W = 5;
    localparam int          FLUSH_CNT_W    = 3;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect squash,
// fetch wait and data-memory wait, with perf counters and a memory timeout flag.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int          FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int          CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_valid,
    input  logic                  dmem_busy,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  cnt_clr,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  mem_timeout
);

    localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES);

    state_t                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_q, flush_d;
    logic [15:0]            wait_q, wait_d;
    logic                   mem_timeout_q, mem_timeout_d;
    logic                   load_use, in_flush, redirect_acc;
    logic [16:0]            wait_inc;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

    // A flush interrupted by a memory wait resumes once the wait ends.
    assign in_flush = (state_q == S_FLUSH) || ((state_q == S_MEMWAIT) && (flush_q != '0));

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        state_d      = S_RUN;
        flush_d      = flush_q;
        redirect_acc = 1'b0;

        if (dmem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            state_d   = S_MEMWAIT;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            redirect_acc = 1'b1;
            flush_d      = FlushLoad;
            state_d      = (FlushLoad == '0) ? S_RUN : S_FLUSH;
        end else if (in_flush) begin
            if_id_flush = 1'b1;
            flush_d     = flush_q - FLUSH_CNT_W'(1);
            state_d     = (flush_d == '0) ? S_RUN : S_FLUSH;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_valid) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end

        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b0;
            ex_mem_en   = 1'b0;
        end
    end

    always_comb begin
        wait_inc      = {1'b0, wait_q} + 17'd1;
        wait_d        = '0;
        mem_timeout_d = mem_timeout_q;
        if (dmem_busy) begin
            wait_d = (wait_q == '1) ? wait_q : wait_inc[15:0];
            if (wait_inc >= 17'(MEM_TIMEOUT)) begin
                mem_timeout_d = 1'b1;
            end
        end
        if (cnt_clr) begin
            mem_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            flush_q       <= '0;
            wait_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_en),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_acc),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: default-width controller plus a CNT_W=4 copy sharing the same inputs.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_valid, dmem_busy;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, cnt_clr;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_ex_mem_en;
    logic        s_mem_timeout;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
    localparam logic [5:0] C_RUN   = 6'b110101;
    localparam logic [5:0] C_OFF   = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b000111;
    localparam logic [5:0] C_REDIR = 6'b111111;
    localparam logic [5:0] C_FLUSH = 6'b111101;
    localparam logic [5:0] C_IMISS = 6'b011101;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .imem_valid(imem_valid), .dmem_busy(dmem_busy),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .cnt_clr(cnt_clr), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .imem_valid(imem_valid), .dmem_busy(dmem_busy),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .cnt_clr(cnt_clr), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
        .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush),
        .ex_mem_en(s_ex_mem_en), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
        .mem_timeout(s_mem_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en},
              {26'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_valid = 1'b1; dmem_busy = 1'b0; ex_redirect = 1'b0; cnt_clr = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) tick();
        #1;
        check_ctrl("ctrl_in_reset", C_OFF);
        check("stall_cnt_reset", stall_cnt, 32'd0);
        check("flush_cnt_reset", flush_cnt, 32'd0);
        check("mem_timeout_reset", {31'd0, mem_timeout}, 32'd0);
        rst = 1'b0;
        #1;
        check_ctrl("ctrl_after_reset", C_RUN);

        // Load-use via rs1
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1 check_ctrl("load_use_rs1", C_LU);
        tick();
        idle();
        #1 check_ctrl("after_load_use", C_RUN);
        check("stall_cnt_lu", stall_cnt, 32'd1);
        // Same pattern to x0 must not stall
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1 check_ctrl("load_use_x0", C_RUN);
        // Matching index but operand unused
        ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b0;
        #1 check_ctrl("load_use_unused", C_RUN);
        tick();
        check("stall_cnt_no_lu", stall_cnt, 32'd1);
        // Load-use via rs2
        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1 check_ctrl("load_use_rs2", C_LU);
        tick();
        idle();
        check("stall_cnt_lu2", stall_cnt, 32'd2);

        // Redirect with one extra squash cycle
        ex_redirect = 1'b1;
        #1 check_ctrl("redirect", C_REDIR);
        tick();
        ex_redirect = 1'b0;
        #1 check_ctrl("flush_cycle", C_FLUSH);
        check("flush_cnt_1", flush_cnt, 32'd1);
        tick();
        #1 check_ctrl("back_to_run", C_RUN);

        // Redirect held behind a 4-cycle memory wait
        dmem_busy = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_ctrl("busy_redirect", C_OFF);
            tick();
        end
        dmem_busy = 1'b0;
        #1 check_ctrl("redirect_after_busy", C_REDIR);
        check("stall_cnt_busy", stall_cnt, 32'd6);
        check("flush_cnt_held", flush_cnt, 32'd1);
        tick();
        ex_redirect = 1'b0;
        check("flush_cnt_2", flush_cnt, 32'd2);
        #1 check_ctrl("flush_after_busy", C_FLUSH);
        tick();

        // Busy in the middle of a flush sequence freezes the squash count
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0; dmem_busy = 1'b1;
        #1 check_ctrl("busy_in_flush", C_OFF);
        tick();
        tick();
        dmem_busy = 1'b0;
        #1 check_ctrl("flush_resumes", C_FLUSH);
        tick();
        #1 check_ctrl("run_after_resume", C_RUN);
        check("stall_cnt_8", stall_cnt, 32'd8);
        check("flush_cnt_3", flush_cnt, 32'd3);

        // Memory timeout
        dmem_busy = 1'b1;
        repeat (254) tick();
        check("timeout_at_254", {31'd0, mem_timeout}, 32'd0);
        tick();
        check("timeout_at_255", {31'd0, mem_timeout}, 32'd1);
        repeat (45) tick();
        dmem_busy = 1'b0;
        tick();
        check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
        check("stall_cnt_308", stall_cnt, 32'd308);
        check("small_stall_sat", {28'd0, s_stall_cnt}, 32'd15);
        // Clear beats a simultaneous stall increment
        cnt_clr = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("timeout_cleared", {31'd0, mem_timeout}, 32'd0);
        check("stall_cnt_clr", stall_cnt, 32'd0);
        check("flush_cnt_clr", flush_cnt, 32'd0);
        check("small_stall_clr", {28'd0, s_stall_cnt}, 32'd0);

        // 20 stalls saturate the 4-bit counter
        repeat (20) tick();
        check("stall_cnt_20", stall_cnt, 32'd20);
        check("small_stall_15", {28'd0, s_stall_cnt}, 32'd15);
        imem_valid = 1'b0;
        #1 check_ctrl("lu_over_imiss", C_LU);
        check("small_lu_over_imiss", {31'd0, s_if_id_en}, 32'd0);
        idle();
        imem_valid = 1'b0;
        #1 check_ctrl("imem_miss", C_IMISS);
        idle();

        // Async reset in the middle of a flush
        tick();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        #2 rst = 1'b1;
        #1 check_ctrl("rst_mid_flush", C_OFF);
        check("flush_cnt_async", flush_cnt, 32'd0);
        rst = 1'b0;
        #1 check_ctrl("run_after_rst_flush", C_RUN);

        // Async reset during a memory wait
        tick();
        dmem_busy = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1 check("stall_cnt_async", stall_cnt, 32'd0);
        dmem_busy = 1'b0;
        rst = 1'b0;
        #1 check_ctrl("run_after_rst_wait", C_RUN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
